arb4_rr: RTL and testbench

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_pkg.sv | 17 +
 rtl/arb4_rr_mux4.sv | 20 ++
 rtl/arb4_rr.sv | 123 ++++++++++++
 tb/tb_arb4_rr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb4_pkg.sv
// Shared types for the 4-way round-robin bus arbiter.
package arb4_pkg;
  localparam int ARB_N = 4;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  typedef logic [1:0] arb_idx_t;

  // First set bit of v at or after ptr, searching upward mod 4; ptr if none.
  function automatic arb_idx_t rr_pick(input logic [ARB_N-1:0] v, input arb_idx_t ptr);
    arb_idx_t idx;
    rr_pick = ptr;
    for (int i = ARB_N-1; i >= 0; i--) begin
      idx = ptr + arb_idx_t'(i);
      if (v[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/arb4_rr_mux4.sv
// 4:1 data mux used as the shared-bus data path.
module Mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/arb4_rr.sv
// 4-requester round-robin burst arbiter with sticky grants and zero-bubble handover.
// ARB4_MAX_BURST_EN: optional per-grant beat limit of MAX_BURST transfers.
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic             busy
);
  arb_state_t state_q, state_d;
  arb_idx_t   sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  arb_idx_t   nxt_ptr, win;
  logic       xfer, rel;

  if (MAX_BURST < 1) begin : g_bad_cfg
    $error("arb4_rr: MAX_BURST must be >= 1");
  end

`ifdef ARB4_MAX_BURST_EN
  localparam int CW = $clog2(MAX_BURST+1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  Mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0(req_data0),
    .d1(req_data1),
    .d2(req_data2),
    .d3(req_data3),
    .s (sel_q),
    .y (out_data)
  );

  assign sel  = sel_q;
  assign busy = (state_q == ARB_GRANT);

  always_comb begin
    req_ready = 4'b0000;
    out_valid = busy & req_valid[sel_q];
    out_last  = out_valid & req_last[sel_q];
    if (busy) req_ready[sel_q] = out_ready;
  end

  assign xfer    = out_valid & out_ready;
  assign nxt_ptr = sel_q + 2'd1;
`ifdef ARB4_MAX_BURST_EN
  assign rel     = xfer & (req_last[sel_q] | (cnt_q == CW'(MAX_BURST-1)));
`else
  assign rel     = xfer & req_last[sel_q];
`endif
  // Idle arbitration starts at rr_ptr; release re-arbitrates from the owner's successor.
  assign win     = rr_pick(req_valid, busy ? nxt_ptr : rr_ptr_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
`ifdef ARB4_MAX_BURST_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          state_d = ARB_GRANT;
          sel_d   = win;
`ifdef ARB4_MAX_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        if (rel) begin
          rr_ptr_d = nxt_ptr;
          if (|req_valid) begin
            sel_d = win;
`ifdef ARB4_MAX_BURST_EN
            cnt_d = '0;
`endif
          end else begin
            state_d = ARB_IDLE;
          end
        end
`ifdef ARB4_MAX_BURST_EN
        else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
`ifdef ARB4_MAX_BURST_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB4_MAX_BURST_EN
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: directed scenarios plus randomized traffic against a behavioural model.
module tb_arb4_rr;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_last, req_ready;
  logic [W-1:0] d [4];
  logic [W-1:0] out_data;
  logic         out_valid, out_last, out_ready, busy;
  logic [1:0]   sel;

  int checks = 0;
  int failures = 0;

  // behavioural model: owner index, pointer, beats in current grant
  int m_busy, m_sel, m_ptr, m_cnt;

  always #5 clk = ~clk;

  arb4_rr #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(d[0]), .req_data1(d[1]), .req_data2(d[2]), .req_data3(d[3]),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p+k)%4]) return (p+k)%4;
    return -1;
  endfunction

  task automatic model_edge();
    int  w;
    bit  x, lim;
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin m_busy = 1; m_sel = w; m_cnt = 0; end
    end else begin
      x = req_valid[m_sel] && out_ready;
      if (x) m_cnt++;
      lim = 0;
`ifdef ARB4_MAX_BURST_EN
      lim = (m_cnt == MB);
`endif
      if (x && (req_last[m_sel] || lim)) begin
        m_ptr = (m_sel + 1) % 4;
        w = pick(req_valid, m_ptr);
        if (w >= 0) begin m_sel = w; m_cnt = 0; end
        else m_busy = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'b0; req_last = 4'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sel !== 2'd0 || req_ready !== 4'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset busy=%b sel=%0d ready=%b valid=%b last=%b exp 0/0/0000/0/0", busy, sel, req_ready, out_valid, out_last);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_latency busy=%b exp 0", busy); end
    tick();
    req_valid = 4'b1100;
    @(negedge clk);
    checks++;
    if (sel !== 2'd2 || busy !== 1'b1 || req_ready !== 4'b0100 || out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== d[2]) begin
      failures++;
      $display("FAIL single_grant sel=%0d busy=%b ready=%b v=%b l=%b data=%h exp 2/1/0100/1/1/%h", sel, busy, req_ready, out_valid, out_last, out_data, d[2]);
    end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || busy !== 1'b1) begin
      failures++; $display("FAIL single_ptr sel=%0d busy=%b exp 3/1", sel, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sel !== 2'(i % 4) || busy !== 1'b1 || out_valid !== 1'b1 || req_ready !== (4'b0001 << (i % 4))) begin
        failures++;
        $display("FAIL rr_order step=%0d sel=%0d busy=%b v=%b ready=%b exp sel=%0d", i, sel, busy, out_valid, req_ready, i % 4);
      end
      tick();
    end
  endtask

  task automatic test_sticky();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    tick();                                   // beat 1
    req_valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sel !== 2'd1 || req_ready[3] !== 1'b0) begin
        failures++;
        $display("FAIL sticky_gap c=%0d v=%b sel=%0d ready=%b exp v=0 sel=1 ready[3]=0", i, out_valid, sel, req_ready);
      end
      tick();
    end
    req_valid = 4'b1010;
    tick();                                   // beat 2
    req_last = 4'b0010;
    @(negedge clk);
    checks++;
    if (out_last !== 1'b1 || sel !== 2'd1 || req_ready !== 4'b0010) begin
      failures++; $display("FAIL sticky_last l=%b sel=%0d ready=%b exp 1/1/0010", out_last, sel, req_ready);
    end
    tick();
    req_last = 4'b0000;
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || busy !== 1'b1) begin
      failures++; $display("FAIL sticky_handover sel=%0d busy=%b exp 3/1", sel, busy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0 || sel !== 2'd0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL stall c=%0d ready=%b sel=%0d v=%b exp 0000/0/1", i, req_ready, sel, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL stall_resume ready=%b exp 0001", req_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0010; out_ready = 1'b1;
    tick();                                   // grant 1
    req_valid = 4'b1010;
    tick();                                   // last of 1, handover to 3
    req_valid = 4'b1000; req_last = 4'b0000;
    tick();                                   // beat 1 of requester 3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sel !== 2'd0 || req_ready !== 4'b0) begin
      failures++; $display("FAIL reset_mid busy=%b sel=%0d ready=%b exp 0/0/0000", busy, sel, req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL reset_ptr sel=%0d busy=%b exp 1/1", sel, busy);
    end
  endtask

`ifdef ARB4_MAX_BURST_EN
  task automatic test_max_burst();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd2) begin failures++; $display("FAIL burst_limit sel=%0d exp 2", sel); end
    req_last = 4'b0100;
    tick();
    req_last = 4'b0000;
    @(negedge clk);
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL burst_resume sel=%0d exp 0", sel); end
  endtask
`endif

  task automatic test_random();
    bit         ev, el;
    logic [3:0] er;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = 4'($urandom);
      req_last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = W'($urandom);
      @(negedge clk);
      ev = (m_busy != 0) && req_valid[m_sel];
      el = ev && req_last[m_sel];
      er = (m_busy != 0) ? (4'(out_ready) << m_sel) : 4'b0;
      checks++;
      if (busy !== (m_busy != 0) || sel !== 2'(m_sel) || out_valid !== ev || out_last !== el ||
          req_ready !== er || (m_busy != 0 && out_data !== d[m_sel])) begin
        failures++;
        $display("FAIL random c=%0d busy=%b sel=%0d v=%b l=%b ready=%b data=%h exp %0d/%0d/%b/%b/%b/%h",
                 c, busy, sel, out_valid, out_last, req_ready, out_data, m_busy, m_sel, ev, el, er, d[m_sel]);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = W'(8'h11 * (i + 1));
    m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_sticky();
    test_stall();
    test_reset_mid();
`ifdef ARB4_MAX_BURST_EN
    test_max_burst();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
